// File: rtl/cache_miss_controller.sv
// Two-line fully associative write-back / write-allocate cache in front of a req/ack RAM.
// Misses evict a dirty victim first, fill the line, then re-run the lookup to finish the access.
//
// state     | meaning
// IDLE      | waiting for cpu_req; request fields captured on acceptance
// COMPARE   | tag lookup; a hit completes the access, a miss selects a victim
// WRITEBACK | dirty victim being written to RAM
// FILL      | missing word being read from RAM into the victim line

module cache_miss_controller #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPARE   = 2'd1,
    S_WRITEBACK = 2'd2,
    S_FILL      = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              miss_q, miss_d;
  logic              victim_q, victim_d;

  logic [1:0]             valid_q, valid_d;
  logic [1:0]             dirty_q, dirty_d;
  logic [1:0][ADDR_W-1:0] tag_q, tag_d;
  logic [1:0][DATA_W-1:0] data_q, data_d;
  logic                   lru_q, lru_d;

  logic              done_pend_q, done_pend_d;
  logic              hit_pend_q, hit_pend_d;
  logic [DATA_W-1:0] rdata_pend_q, rdata_pend_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              hit_q, hit_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic hit0, hit1, hit_any, hit_idx;
  logic victim_sel, victim_dirty, mem_fire;

  always_comb begin
    hit0    = valid_q[0] && (tag_q[0] == addr_q);
    hit1    = valid_q[1] && (tag_q[1] == addr_q);
    hit_any = hit0 || hit1;
    hit_idx = ~hit0;
    if (!valid_q[0]) begin
      victim_sel = 1'b0;
    end else if (!valid_q[1]) begin
      victim_sel = 1'b1;
    end else begin
      victim_sel = lru_q;
    end
    victim_dirty = valid_q[victim_sel] && dirty_q[victim_sel];
    // An ack only counts while a request is actually outstanding.
    mem_fire     = mem_req_q && mem_ack;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (hit_any)           state_d = S_IDLE;
        else if (victim_dirty) state_d = S_WRITEBACK;
        else                   state_d = S_FILL;
      end
      S_WRITEBACK: begin
        if (mem_fire) state_d = S_FILL;
      end
      S_FILL: begin
        if (mem_fire) state_d = S_COMPARE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    miss_d       = miss_q;
    victim_d     = victim_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    lru_d        = lru_q;
    done_pend_d  = 1'b0;
    hit_pend_d   = hit_pend_q;
    rdata_pend_d = rdata_pend_q;
    rdata_d      = rdata_q;
    hit_d        = hit_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    busy_d       = (state_d != S_IDLE);

    // Completion is published one cycle after the lookup that resolved it.
    done_d = done_pend_q;
    if (done_pend_q) begin
      rdata_d = rdata_pend_q;
      hit_d   = hit_pend_q;
      if (hit_pend_q) hit_cnt_d  = hit_cnt_q + CNT_W'(1);
      else            miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          miss_d  = 1'b0;
        end
      end
      S_COMPARE: begin
        if (hit_any) begin
          done_pend_d = 1'b1;
          hit_pend_d  = ~miss_q;
          lru_d       = ~hit_idx;
          if (we_q) begin
            data_d[hit_idx]  = wdata_q;
            dirty_d[hit_idx] = 1'b1;
            rdata_pend_d     = wdata_q;
          end else begin
            rdata_pend_d = data_q[hit_idx];
          end
        end else begin
          miss_d    = 1'b1;
          victim_d  = victim_sel;
          mem_req_d = 1'b1;
          if (victim_dirty) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = tag_q[victim_sel];
            mem_wdata_d = data_q[victim_sel];
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = addr_q;
          end
        end
      end
      S_WRITEBACK: begin
        // mem_req stays high: the fill request follows the writeback directly.
        if (mem_fire) begin
          dirty_d[victim_q] = 1'b0;
          mem_we_d          = 1'b0;
          mem_addr_d        = addr_q;
        end
      end
      S_FILL: begin
        if (mem_fire) begin
          tag_d[victim_q]   = addr_q;
          data_d[victim_q]  = mem_rdata;
          valid_d[victim_q] = 1'b1;
          dirty_d[victim_q] = 1'b0;
          mem_req_d         = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      miss_q       <= 1'b0;
      victim_q     <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
      tag_q        <= '0;
      data_q       <= '0;
      lru_q        <= 1'b0;
      done_pend_q  <= 1'b0;
      hit_pend_q   <= 1'b0;
      rdata_pend_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rdata_q      <= '0;
      hit_q        <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      miss_q       <= miss_d;
      victim_q     <= victim_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      lru_q        <= lru_d;
      done_pend_q  <= done_pend_d;
      hit_pend_q   <= hit_pend_d;
      rdata_pend_q <= rdata_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      hit_q        <= hit_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign cpu_busy  = busy_q;
  assign cpu_done  = done_q;
  assign cpu_rdata = rdata_q;
  assign cpu_hit   = hit_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: doc/cache_miss_controller.md
Name: cache_miss_controller

Overview:
- Cache controller between the processor-side request interface and the direct-mapped RAM (memoriaRAM-style 8-bit address/8-bit data).
- Owns a 2-line fully associative L1 array: valid, dirty, tag and data per line, plus a single LRU pointer.
- Policy: write-back, write-allocate.
- On a miss it writes back a dirty victim, fills the line from RAM over a req/ack handshake, then completes the access.

Parameters:
- ADDR_W, 8, address width; also the tag width (one word per line).
- DATA_W, 8, data word width.
- CNT_W, 8, width of the hit and miss statistics counters.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  access address.
- cpu_wdata  in  DATA_W  write data.
- cpu_busy  out  1  high whenever the FSM is not in IDLE.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid while cpu_done=1, held until the next completion.
- cpu_hit  out  1  valid with cpu_done; 1 if the first lookup hit.
- mem_req  out  1  RAM request; held until mem_ack.
- mem_we  out  1  RAM write (writeback) when 1, read (fill) when 0.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  writeback data.
- mem_ack  in  1  RAM completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  fill data.
- hit_cnt  out  CNT_W  completed accesses that hit; wraps modulo 2^CNT_W.
- miss_cnt  out  CNT_W  completed accesses that missed; wraps.

Behaviour:
- Reset (async on reset_n=0):
  - both lines: valid=0, dirty=0; tag and data cleared to 0.
  - lru=0; state=IDLE.
  - all outputs 0, including both counters.
  - Reset mid-transaction abandons it; mem_req drops immediately, with no partial line update.
- All outputs are registered.
- States: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE:
  - cpu_req=1 latches we/addr/wdata, clears the internal miss flag, and moves to COMPARE.
  - cpu_req is ignored in every other state.
- COMPARE, hit (valid && tag==addr on line i):
  - read: cpu_rdata=data[i].
  - write: data[i]=wdata, dirty[i]=1.
  - lru=~i; cpu_done=1 next cycle.
  - cpu_hit = !miss flag; increment hit_cnt or miss_cnt accordingly.
  - Return to IDLE.
  - Hit latency: request sampled at edge N, cpu_done high in the cycle after edge N+2.
- COMPARE, miss:
  - Set the miss flag.
  - Victim = lowest-index invalid line, else line lru.
  - Victim valid && dirty: go to WRITEBACK with mem_req=1, mem_we=1, mem_addr=tag[v], mem_wdata=data[v].
  - Otherwise: go to FILL with mem_req=1, mem_we=0, mem_addr=addr.
- WRITEBACK:
  - Hold mem_* stable until mem_ack.
  - On ack: dirty[v]=0, then issue the fill request (mem_we=0, mem_addr=addr) and go to FILL.
  - mem_req stays high across the transition.
- FILL:
  - Hold until mem_ack.
  - On ack: tag[v]=addr, data[v]=mem_rdata, valid[v]=1, dirty[v]=0; mem_req=0; return to COMPARE.
  - The re-lookup now hits and applies the read or write (write-allocate); cpu_hit=0.
- LRU rules:
  - Updated only in COMPARE on the hit path.
  - Fill and writeback do not change it.
- mem_ack while mem_req=0 is ignored.
- The RAM may ack in the same cycle mem_req rises (the earliest is the cycle after the request edge).
- cpu_busy=1 from the edge that accepts a request until the edge that returns to IDLE.
- Counters wrap from 2^CNT_W-1 to 0.

Test Plan:
- Cold read miss:
  - Stimulus: after reset, read 100; RAM returns 5 with 1-cycle ack.
  - Required: one fill at mem_addr=100 (no writeback); cpu_done with cpu_rdata=5, cpu_hit=0; miss_cnt=1.
- Read hit:
  - Stimulus: read 100 again.
  - Required: no mem_req; cpu_done exactly 2 cycles after acceptance; rdata=5, hit=1; hit_cnt=1.
- Write hit, dirty eviction, then fill:
  - Stimulus: write 100 := 0x2A (hit); read 101 (fills line 1, data 3); read 102.
  - Required: victim is line 0 (LRU); WRITEBACK mem_we=1, addr=100, wdata=0x2A; then FILL addr=102; rdata=1.
- Write miss, allocate:
  - Stimulus: write 103 := 0x77 into a clean victim.
  - Required: fill only, no writeback; line ends valid, dirty, data 0x77.
  - A following read of 103 hits with 0x77.
- Mid-fill reset:
  - Stimulus: assert reset_n=0 while mem_req=1 in FILL.
  - Required: mem_req=0 and cpu_busy=0 immediately; counters 0; a later read of the same address misses.
- Busy / ack-gating:
  - Stimulus: pulse cpu_req during FILL; stall mem_ack for 5 cycles.
  - Required: the extra request is ignored; mem_addr, mem_we and mem_wdata stay stable throughout; exactly one cpu_done.
